// File: rtl/hilo_ctrl.sv
// HI/LO write-port owner: sequences 32-step shift-add multiply and restoring
// divide, plus single-cycle MTHI/MTLO, into one combined HI/LO write.
module hilo_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             cancel,
  input  logic [WIDTH-1:0] hi_cur,
  input  logic [WIDTH-1:0] lo_cur,
  output logic             busy,
  output logic             done,
  output logic             whilo,
  output logic [WIDTH-1:0] hi_w,
  output logic [WIDTH-1:0] lo_w,
  output logic             div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start; MTHI/MTLO written directly from here
  // MUL   | one shift-add step per cycle, counter WIDTH-1 down to 0
  // DIV   | one restoring-divide step per cycle, counter WIDTH-1 down to 0
  // FIX   | sign correction, result loaded into hi_w/lo_w
  // WRITE | whilo/done pulse, then back to IDLE
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WRITE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   rs_save;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_lo;
  logic               neg_hi;
  logic               dbz;

  logic               signed_op;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_neg;

  always_comb begin
    signed_op = ~op[0];
    rs_mag    = (signed_op && rs_i[WIDTH-1]) ? -rs_i : rs_i;
    rt_mag    = (signed_op && rt_i[WIDTH-1]) ? -rt_i : rt_i;
    // acc = {partial product, remaining multiplier bits}
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    // acc = {partial remainder, dividend bits shifting out / quotient shifting in}
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb});
    div_sub   = div_shift[WIDTH-1:0] - opb;
    prod_neg  = -acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      whilo       <= 1'b0;
      div_by_zero <= 1'b0;
      hi_w        <= '0;
      lo_w        <= '0;
      acc         <= '0;
      opb         <= '0;
      rs_save     <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz         <= 1'b0;
    end else begin
      whilo       <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              3'b100: begin
                whilo <= 1'b1;
                hi_w  <= rs_i;
                lo_w  <= lo_cur;
              end
              3'b101: begin
                whilo <= 1'b1;
                hi_w  <= hi_cur;
                lo_w  <= rs_i;
              end
              3'b000, 3'b001: begin
                acc    <= {{WIDTH{1'b0}}, rt_mag};
                opb    <= rs_mag;
                neg_lo <= signed_op && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                neg_hi <= 1'b0;
                is_div <= 1'b0;
                dbz    <= 1'b0;
                cnt    <= CW'(WIDTH-1);
                busy   <= 1'b1;
                state  <= MUL;
              end
              3'b010, 3'b011: begin
                acc     <= {{WIDTH{1'b0}}, rs_mag};
                opb     <= rt_mag;
                rs_save <= rs_i;
                neg_lo  <= signed_op && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                neg_hi  <= signed_op && rs_i[WIDTH-1];
                is_div  <= 1'b1;
                dbz     <= (rt_i == '0);
                cnt     <= CW'(WIDTH-1);
                busy    <= 1'b1;
                state   <= DIV;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (cancel) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (div_ge) acc <= {div_sub, acc[WIDTH-2:0], 1'b1};
            else        acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FIX: begin
          busy <= 1'b0;
          if (cancel) begin
            state <= IDLE;
          end else begin
            whilo <= 1'b1;
            done  <= 1'b1;
            state <= WRITE;
            if (dbz) begin
              hi_w        <= rs_save;
              lo_w        <= '1;
              div_by_zero <= 1'b1;
            end else if (!is_div) begin
              {hi_w, lo_w} <= neg_lo ? prod_neg : acc;
            end else begin
              hi_w <= neg_hi ? prod_neg[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, (acc[WIDTH-1:0] != '0)}
                             : acc[2*WIDTH-1:WIDTH];
              lo_w <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
          end
        end
        WRITE: state <= IDLE;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed-vector bench for hilo_ctrl: table of mul/div/MT ops plus
// hand-written sequences for ignore-while-busy, cancel and mid-op reset.
module tb_hilo_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] rs_i = '0, rt_i = '0, hi_cur = '0, lo_cur = '0;
  logic         busy, done, whilo, div_by_zero;
  logic [W-1:0] hi_w, lo_w;

  int tests = 0;
  int fails = 0;

  hilo_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_i(rs_i), .rt_i(rt_i), .cancel(cancel),
    .hi_cur(hi_cur), .lo_cur(lo_cur),
    .busy(busy), .done(done), .whilo(whilo),
    .hi_w(hi_w), .lo_w(lo_w), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] rs, rt, hic, loc, ehi, elo;
    logic         edbz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    op = v.op; rs_i = v.rs; rt_i = v.rt; hi_cur = v.hic; lo_cur = v.loc;
    start = 1'b1;
    tick();
    start = 1'b0;
    rs_i = ~v.rs; rt_i = ~v.rt; hi_cur = ~v.hic; lo_cur = ~v.loc;
    if (v.op[2]) begin
      chk({tag, "_whilo"}, W'(whilo), 1);
      chk({tag, "_busy"},  W'(busy), 0);
      chk({tag, "_done"},  W'(done), 0);
      chk({tag, "_hi"},    hi_w, v.ehi);
      chk({tag, "_lo"},    lo_w, v.elo);
      tick();
      chk({tag, "_whilo_off"}, W'(whilo), 0);
    end else begin
      int bad = 0;
      for (int c = 1; c <= 33; c++) begin
        if (busy !== 1'b1 || whilo !== 1'b0 || done !== 1'b0) bad++;
        tick();
      end
      chk({tag, "_busy_window"}, W'(bad), 0);
      chk({tag, "_whilo"}, W'(whilo), 1);
      chk({tag, "_done"},  W'(done), 1);
      chk({tag, "_busy"},  W'(busy), 0);
      chk({tag, "_hi"},    hi_w, v.ehi);
      chk({tag, "_lo"},    lo_w, v.elo);
      chk({tag, "_dbz"},   W'(div_by_zero), W'(v.edbz));
      tick();
      chk({tag, "_whilo_off"}, W'(whilo | done | div_by_zero), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int wcount, wcyc;
    logic [W-1:0] whi, wlo;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000005, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{3'b000, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[3]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h00000001, 1'b0};
    vecs[4]  = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{3'b011, 32'h00000064, 32'h00000007, 32'h0, 32'h0, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[8]  = '{3'b011, 32'h12345678, 32'h00000000, 32'h0, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'b010, 32'hFFFFFFF9, 32'h00000000, 32'h0, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'b100, 32'hAAAA5555, 32'h0, 32'h22222222, 32'h11111111, 32'hAAAA5555, 32'h11111111, 1'b0};
    vecs[11] = '{3'b101, 32'h5A5A5A5A, 32'h0, 32'h33333333, 32'h44444444, 32'h33333333, 32'h5A5A5A5A, 1'b0};

    tick();
    tick();
    chk("reset_busy",  W'(busy), 0);
    chk("reset_whilo", W'(whilo | done | div_by_zero), 0);
    chk("reset_hi",    hi_w, 0);
    chk("reset_lo",    lo_w, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // second start while busy is dropped
    op = 3'b000; rs_i = 32'hFFFFFFFD; rt_i = 32'h5; start = 1'b1;
    tick();
    wcount = 0; wcyc = 0; whi = '0; wlo = '0;
    for (int c = 1; c <= 45; c++) begin
      if (whilo) begin wcount++; wcyc = c; whi = hi_w; wlo = lo_w; end
      if (c == 10) begin op = 3'b001; rs_i = 32'hFFFFFFFF; rt_i = 32'hFFFFFFFF; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
    chk("busy_start_wcount", W'(wcount), 1);
    chk("busy_start_wcyc",   W'(wcyc), 34);
    chk("busy_start_hi",     whi, 32'hFFFFFFFF);
    chk("busy_start_lo",     wlo, 32'hFFFFFFF1);

    // cancel in cycle 20 of MULT
    op = 3'b000; rs_i = 32'h3; rt_i = 32'h7; start = 1'b1;
    tick();
    start = 1'b0;
    wcount = 0;
    for (int c = 1; c <= 50; c++) begin
      if (whilo || done || div_by_zero) wcount++;
      if (c == 21) begin chk("cancel_busy_c21", W'(busy), 0); cancel = 1'b0; end
      if (c == 20) cancel = 1'b1;
      tick();
    end
    chk("cancel_no_write", W'(wcount), 0);

    // cancel during FIX (cycle 33) of DIV
    op = 3'b010; rs_i = 32'h64; rt_i = 32'h7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) tick();
    chk("fix_cancel_busy_c33", W'(busy), 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("fix_cancel_busy", W'(busy), 0);
    chk("fix_cancel_write", W'(whilo | done | div_by_zero), 0);
    tick();

    // cancel together with start, and reserved op
    op = 3'b000; rs_i = 32'h2; rt_i = 32'h2; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", W'(busy | whilo), 0);
    tick();
    chk("start_cancel_busy2", W'(busy | whilo), 0);
    op = 3'b110; start = 1'b1;
    tick();
    start = 1'b0;
    chk("reserved_op", W'(busy | whilo | done), 0);
    tick();

    // async reset in cycle 15 of DIVU, then a clean MULTU
    op = 3'b011; rs_i = 32'h64; rt_i = 32'h7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    chk("pre_reset_busy", W'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_busy", W'(busy | done | whilo | div_by_zero), 0);
    chk("mid_reset_hi",   hi_w, 0);
    chk("mid_reset_lo",   lo_w, 0);
    tick();
    tick();
    reset_n = 1'b1;
    wcount = 0;
    for (int c = 0; c < 25; c++) begin
      if (busy || whilo) wcount++;
      tick();
    end
    chk("post_reset_idle", W'(wcount), 0);
    v = '{3'b001, 32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h00000001, 32'h00000000, 1'b0};
    run_vec(v, "post_reset_multu");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the single write port of the HI/LO register pair (whilo, hi_i, lo_i). Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage. Runs 32-iteration shift-add multiply or restoring divide, then issues exactly one combined HI/LO write. Supplies busy for pipeline stall and accepts cancel for flushes.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; the iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  operation request, sampled only in IDLE
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
rs_i  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
rt_i  input  WIDTH  multiplier / divisor
cancel  input  1  pipeline flush; aborts the in-flight operation
hi_cur  input  WIDTH  current HI register output
lo_cur  input  WIDTH  current LO register output
busy  output  1  operation in progress; EX must stall
done  output  1  one-cycle pulse, coincident with the mul/div write
whilo  output  1  HI/LO write enable, one-cycle pulse
hi_w  output  WIDTH  HI write data
lo_w  output  WIDTH  LO write data
div_by_zero  output  1  one-cycle pulse with done when DIV/DIVU had rt_i==0

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- Reset, asynchronous: state=IDLE; busy, done, whilo, div_by_zero = 0; hi_w, lo_w, counter and internal accumulators = 0. Reset mid-operation discards the operation and produces no write.
- All outputs are registered.
- States: IDLE, MUL, DIV, FIX, WRITE.
- IDLE, start=1, cancel=0:
  - MTHI: next cycle whilo=1, hi_w=rs_i, lo_w=lo_cur (sampled at the start cycle). busy stays 0, done stays 0, state stays IDLE.
  - MTLO: next cycle whilo=1, hi_w=hi_cur, lo_w=rs_i. busy stays 0, done stays 0, state stays IDLE.
  - MULT/MULTU: latch |rs_i| and |rt_i|; signed ops use magnitude and record the result sign. Go to MUL.
  - DIV/DIVU: latch magnitudes and record the quotient sign and remainder sign. Go to DIV.
  - Reserved op: ignored, no state change.
- Mul/div timing, with the start cycle as cycle 0:
  - Cycles 1..WIDTH: MUL or DIV, one iteration per cycle, counter WIDTH-1 down to 0.
  - Cycle WIDTH+1: FIX, applies two's-complement sign correction.
  - Cycle WIDTH+2: WRITE. whilo=1, done=1, hi_w/lo_w valid, then return to IDLE.
  - busy=1 during cycles 1..WIDTH+1 and 0 in WRITE, so the stalled instruction releases with the write.
  - Total latency is 34 cycles for WIDTH=32.
- MUL: unsigned 2*WIDTH-bit shift-add. If the sign flag is set, FIX negates the 2*WIDTH-bit product. HI=upper half, LO=lower half.
- DIV: restoring division on magnitudes.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - HI=remainder, LO=quotient.
  - 0x80000000 / -1 yields LO=0x80000000, HI=0.
- Divide by zero (detected at start): iterations still run for fixed latency. Write HI=rs_i, LO=all ones, no sign fix, div_by_zero=1 with done.
- start while busy, or in FIX/WRITE: ignored, with no queuing.
- cancel=1 in MUL/DIV/FIX: next cycle goes to IDLE with busy=0 and no whilo, done or div_by_zero. cancel in WRITE has no effect; the write completes. cancel with start in IDLE: cancel wins and the request is dropped.
- The block never asserts whilo in two consecutive cycles from one request.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy in cycles 1..33; cycle 34: whilo=done=1, hi_w=0xFFFFFFFE, lo_w=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> cycle 34: hi_w=0xFFFFFFFF, lo_w=0xFFFFFFF1. DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo_w=0xFFFFFFFD, hi_w=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo_w=0x80000000, hi_w=0.
- DIVU rs=0x12345678, rt=0 -> cycle 34: hi_w=0x12345678, lo_w=0xFFFFFFFF, div_by_zero=done=1.
- MTHI rs=0xAAAA5555 with lo_cur=0x11111111 -> next cycle: whilo=1, hi_w=0xAAAA5555, lo_w=0x11111111, busy=0, done=0. Repeat for MTLO with hi_cur preserved.
- MULT started, second start in cycle 10 -> second request ignored, single write at cycle 34. Separately, cancel in cycle 20 -> busy=0 at cycle 21, no whilo ever.
- reset_n low in cycle 15 of DIVU -> all outputs 0 immediately. A new MULTU after release completes normally with correct values.
